// File: rtl/calendar_date.sv
// calendar_date: day-of-month / month counter of the calendar chain.
// Advances the date on i_day_tick with leap-year-aware month lengths and
// emits a registered one-cycle o_year_tick on each Dec 31 -> Jan 1 rollover.
// The current year is read back from the year counter to size February.
//
// Build option: CALENDAR_GREGORIAN_EN
//   defined   - full Gregorian leap rule (div 4, not div 100 unless div 400)
//   undefined - Julian-style rule (div 4 only)
//
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_srst                  synchronous reset to 1 January
//   i_day_tick              one-cycle "one day elapsed" pulse
//   i_year                  current year from the year counter
//   i_load/_day/_month      one-cycle date load request and value
//   o_day, o_month          current date (1..31, 1..12)
//   o_leap                  combinational leap flag for i_year
//   o_year_tick             registered one-cycle rollover pulse
//   o_load_err              registered one-cycle pulse on rejected load
module calendar_date #(
  parameter int unsigned YEAR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_srst,
  input  logic              i_day_tick,
  input  logic [YEAR_W-1:0] i_year,
  input  logic              i_load,
  input  logic [4:0]        i_load_day,
  input  logic [3:0]        i_load_month,
  output logic [4:0]        o_day,
  output logic [3:0]        o_month,
  output logic              o_leap,
  output logic              o_year_tick,
  output logic              o_load_err
);

  localparam int unsigned DAY_W = 5;
  localparam int unsigned MON_W = 4;

  logic [DAY_W-1:0] r_day;
  logic [MON_W-1:0] r_month;
  logic             r_year_tick;
  logic             r_load_err;

  logic [DAY_W-1:0] w_day_nxt;
  logic [MON_W-1:0] w_month_nxt;
  logic             w_year_tick_nxt;
  logic             w_load_err_nxt;
  logic [DAY_W-1:0] w_dim_cur;
  logic [DAY_W-1:0] w_dim_load;
  logic             w_load_ok;

  // Month length lookup; February depends on the leap flag.
  function automatic logic [DAY_W-1:0] days_in_month(input logic [MON_W-1:0] m,
                                                     input logic leap);
    logic [DAY_W-1:0] d;
    case (m)
      4'd2:                   d = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      default:                d = 5'd31;
    endcase
    return d;
  endfunction

  // Leap-year flag for the year currently presented by the year counter.
`ifdef CALENDAR_GREGORIAN_EN
  logic w_div4;
  logic w_div100;
  logic w_div400;
  assign w_div4   = (i_year[1:0] == 2'b00);
  assign w_div100 = ((i_year % YEAR_W'(100)) == '0);
  assign w_div400 = ((i_year % YEAR_W'(400)) == '0);
  assign o_leap   = w_div4 && (!w_div100 || w_div400);
`else
  assign o_leap   = (i_year[1:0] == 2'b00);
`endif

  assign w_dim_cur  = days_in_month(r_month, o_leap);
  assign w_dim_load = days_in_month(i_load_month, o_leap);

  assign w_load_ok = (i_load_month >= 4'd1) && (i_load_month <= 4'd12) &&
                     (i_load_day != 5'd0) && (i_load_day <= w_dim_load);

  // Next-state: srst beats load beats day tick; a load always swallows the tick.
  always_comb begin
    w_day_nxt       = r_day;
    w_month_nxt     = r_month;
    w_year_tick_nxt = 1'b0;
    w_load_err_nxt  = 1'b0;
    if (i_srst) begin
      w_day_nxt   = 5'd1;
      w_month_nxt = 4'd1;
    end else if (i_load) begin
      if (w_load_ok) begin
        w_day_nxt   = i_load_day;
        w_month_nxt = i_load_month;
      end else begin
        w_load_err_nxt = 1'b1;
      end
    end else if (i_day_tick) begin
      // >= so a stale Feb 29 (year changed underneath) still rolls to Mar 1.
      if (r_day < w_dim_cur) begin
        w_day_nxt = r_day + 5'd1;
      end else if (r_month < 4'd12) begin
        w_day_nxt   = 5'd1;
        w_month_nxt = r_month + 4'd1;
      end else begin
        w_day_nxt       = 5'd1;
        w_month_nxt     = 4'd1;
        w_year_tick_nxt = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_day       <= 5'd1;
      r_month     <= 4'd1;
      r_year_tick <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_day       <= w_day_nxt;
      r_month     <= w_month_nxt;
      r_year_tick <= w_year_tick_nxt;
      r_load_err  <= w_load_err_nxt;
    end
  end

  assign o_day       = r_day;
  assign o_month     = r_month;
  assign o_year_tick = r_year_tick;
  assign o_load_err  = r_load_err;

endmodule

// File: tb/tb_calendar_date.sv
// tb_calendar_date: directed, table-driven bench for calendar_date.
// Each table row is one clock edge of stimulus plus the expected state after it.
// A small year counter can be switched in to follow o_year_tick.
module tb_calendar_date;

  logic        clk;
  logic        rst_n;
  logic        srst;
  logic        day_tick;
  logic        load;
  logic [4:0]  ld_day;
  logic [3:0]  ld_month;
  logic [11:0] year_drv;
  logic [11:0] year_cnt;
  logic        yc_on;
  logic [11:0] year;
  logic [4:0]  day;
  logic [3:0]  month;
  logic        leap;
  logic        year_tick;
  logic        load_err;

  int checks;
  int errors;

  typedef struct {
    logic        srst;
    logic        load;
    logic        tick;
    logic [4:0]  ld_day;
    logic [3:0]  ld_mon;
    logic [11:0] year;
    logic [4:0]  e_day;
    logic [3:0]  e_mon;
    logic        e_leap;
    logic        e_yt;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

`ifdef CALENDAR_GREGORIAN_EN
  localparam logic L2100 = 1'b0;
`else
  localparam logic L2100 = 1'b1;
`endif

  calendar_date #(.YEAR_W(12)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_srst       (srst),
    .i_day_tick   (day_tick),
    .i_year       (year),
    .i_load       (load),
    .i_load_day   (ld_day),
    .i_load_month (ld_month),
    .o_day        (day),
    .o_month      (month),
    .o_leap       (leap),
    .o_year_tick  (year_tick),
    .o_load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference year counter: follows year_drv until enabled, then counts ticks.
  always @(posedge clk) begin
    if (!yc_on) year_cnt <= year_drv;
    else if (year_tick) year_cnt <= year_cnt + 12'd1;
  end
  assign year = yc_on ? year_cnt : year_drv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic s, input logic l, input logic t,
                     input logic [4:0] ld, input logic [3:0] lm, input logic [11:0] y,
                     input logic [4:0] ed, input logic [3:0] em,
                     input logic el, input logic eyt, input logic eerr);
    vec_t v;
    v.srst = s; v.load = l; v.tick = t; v.ld_day = ld; v.ld_mon = lm; v.year = y;
    v.e_day = ed; v.e_mon = em; v.e_leap = el; v.e_yt = eyt; v.e_err = eerr;
    vq.push_back(v);
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    srst = v.srst; load = v.load; day_tick = v.tick;
    ld_day = v.ld_day; ld_month = v.ld_mon; year_drv = v.year;
    @(posedge clk);
    #1;
    srst = 1'b0; load = 1'b0; day_tick = 1'b0;
    check({tag, " day"},   32'(day),       32'(v.e_day));
    check({tag, " month"}, 32'(month),     32'(v.e_mon));
    check({tag, " leap"},  32'(leap),      32'(v.e_leap));
    check({tag, " ytick"}, 32'(year_tick), 32'(v.e_yt));
    check({tag, " lderr"}, 32'(load_err),  32'(v.e_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    checks = 0; errors = 0;
    rst_n = 1'b0; srst = 1'b0; day_tick = 1'b0; load = 1'b0;
    ld_day = 5'd0; ld_month = 4'd0; year_drv = 12'd1970; yc_on = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst day",   32'(day),       32'd1);
    check("rst month", 32'(month),     32'd1);
    check("rst ytick", 32'(year_tick), 32'd0);
    check("rst lderr", 32'(load_err),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // January 1970: 31 ticks walk to Feb 1.
    for (int k = 1; k <= 31; k++) begin
      v = '{srst: 1'b0, load: 1'b0, tick: 1'b1, ld_day: 5'd0, ld_mon: 4'd0,
            year: 12'd1970, e_day: (k < 31) ? 5'(k + 1) : 5'd1,
            e_mon: (k < 31) ? 4'd1 : 4'd2, e_leap: 1'b0, e_yt: 1'b0, e_err: 1'b0};
      apply(v, $sformatf("jan%0d", k));
    end

    //   srst load tick ld_d  ld_m  year     day   mon  leap   yt err
    add(0, 1, 0, 5'd28, 4'd2,  12'd1972, 5'd28, 4'd2,  1, 0, 0);
    add(0, 0, 1, 5'd0,  4'd0,  12'd1972, 5'd29, 4'd2,  1, 0, 0);
    add(0, 0, 1, 5'd0,  4'd0,  12'd1972, 5'd1,  4'd3,  1, 0, 0);
    add(0, 1, 0, 5'd28, 4'd2,  12'd1970, 5'd28, 4'd2,  0, 0, 0);
    add(0, 0, 1, 5'd0,  4'd0,  12'd1970, 5'd1,  4'd3,  0, 0, 0);
    add(0, 1, 0, 5'd28, 4'd2,  12'd2100, 5'd28, 4'd2,  L2100, 0, 0);
    add(0, 0, 1, 5'd0,  4'd0,  12'd2100, L2100 ? 5'd29 : 5'd1, L2100 ? 4'd2 : 4'd3, L2100, 0, 0);
    add(0, 1, 0, 5'd28, 4'd2,  12'd2000, 5'd28, 4'd2,  1, 0, 0);
    add(0, 0, 1, 5'd0,  4'd0,  12'd2000, 5'd29, 4'd2,  1, 0, 0);
    // Stale Feb 29: year changes under it, next tick goes to Mar 1.
    add(0, 1, 0, 5'd29, 4'd2,  12'd1972, 5'd29, 4'd2,  1, 0, 0);
    add(0, 0, 1, 5'd0,  4'd0,  12'd1973, 5'd1,  4'd3,  0, 0, 0);
    // Invalid loads: date held, error pulses, coincident tick dropped.
    add(0, 1, 0, 5'd1,  4'd13, 12'd1970, 5'd1,  4'd3,  0, 0, 1);
    add(0, 0, 0, 5'd0,  4'd0,  12'd1970, 5'd1,  4'd3,  0, 0, 0);
    add(0, 1, 1, 5'd31, 4'd4,  12'd1970, 5'd1,  4'd3,  0, 0, 1);
    add(0, 1, 0, 5'd29, 4'd2,  12'd1971, 5'd1,  4'd3,  0, 0, 1);
    add(0, 1, 0, 5'd0,  4'd5,  12'd1970, 5'd1,  4'd3,  0, 0, 1);
    add(0, 1, 0, 5'd5,  4'd0,  12'd1970, 5'd1,  4'd3,  0, 0, 1);
    add(0, 0, 0, 5'd0,  4'd0,  12'd1970, 5'd1,  4'd3,  0, 0, 0);
    // Valid boundaries and ordinary month rollovers.
    add(0, 1, 0, 5'd30, 4'd4,  12'd1970, 5'd30, 4'd4,  0, 0, 0);
    add(0, 0, 1, 5'd0,  4'd0,  12'd1970, 5'd1,  4'd5,  0, 0, 0);
    add(0, 1, 0, 5'd30, 4'd11, 12'd1970, 5'd30, 4'd11, 0, 0, 0);
    add(0, 0, 1, 5'd0,  4'd0,  12'd1970, 5'd1,  4'd12, 0, 0, 0);
    add(0, 0, 1, 5'd0,  4'd0,  12'd1970, 5'd2,  4'd12, 0, 0, 0);
    // Simultaneous events at 12/31.
    add(0, 1, 0, 5'd31, 4'd12, 12'd1970, 5'd31, 4'd12, 0, 0, 0);
    add(0, 1, 1, 5'd15, 4'd6,  12'd1970, 5'd15, 4'd6,  0, 0, 0);
    add(0, 1, 0, 5'd31, 4'd12, 12'd1970, 5'd31, 4'd12, 0, 0, 0);
    add(1, 0, 1, 5'd0,  4'd0,  12'd1970, 5'd1,  4'd1,  0, 0, 0);
    add(0, 1, 0, 5'd31, 4'd12, 12'd1970, 5'd31, 4'd12, 0, 0, 0);
    add(1, 1, 0, 5'd15, 4'd6,  12'd1970, 5'd1,  4'd1,  0, 0, 0);
    add(0, 1, 0, 5'd31, 4'd12, 12'd1970, 5'd31, 4'd12, 0, 0, 0);
    add(1, 1, 0, 5'd0,  4'd13, 12'd1970, 5'd1,  4'd1,  0, 0, 0);
    // Year rollover pulse is exactly one cycle wide.
    add(0, 1, 0, 5'd31, 4'd12, 12'd1970, 5'd31, 4'd12, 0, 0, 0);
    add(0, 0, 1, 5'd0,  4'd0,  12'd1970, 5'd1,  4'd1,  0, 1, 0);
    add(0, 0, 0, 5'd0,  4'd0,  12'd1970, 5'd1,  4'd1,  0, 0, 0);
    add(0, 0, 1, 5'd0,  4'd0,  12'd1970, 5'd2,  4'd1,  0, 0, 0);

    foreach (vq[i]) apply(vq[i], $sformatf("vec%0d", i));

    // Year counter in the loop: i_year advances two cycles after the tick.
    @(negedge clk);
    year_drv = 12'd1970;
    @(negedge clk);
    yc_on = 1'b1;
    v = '{srst: 1'b0, load: 1'b1, tick: 1'b0, ld_day: 5'd31, ld_mon: 4'd12,
          year: 12'd1970, e_day: 5'd31, e_mon: 4'd12, e_leap: 1'b0, e_yt: 1'b0, e_err: 1'b0};
    apply(v, "yc_load");
    v = '{srst: 1'b0, load: 1'b0, tick: 1'b1, ld_day: 5'd0, ld_mon: 4'd0,
          year: 12'd1970, e_day: 5'd1, e_mon: 4'd1, e_leap: 1'b0, e_yt: 1'b1, e_err: 1'b0};
    apply(v, "yc_tick");
    check("yc year e0", 32'(year), 32'd1970);
    v.tick = 1'b0; v.e_yt = 1'b0;
    apply(v, "yc_after");
    check("yc year e1", 32'(year), 32'd1971);
    @(negedge clk);
    yc_on = 1'b0;

    // Async reset right after the rollover clears the pending pulse at once.
    v = '{srst: 1'b0, load: 1'b1, tick: 1'b0, ld_day: 5'd31, ld_mon: 4'd12,
          year: 12'd1970, e_day: 5'd31, e_mon: 4'd12, e_leap: 1'b0, e_yt: 1'b0, e_err: 1'b0};
    apply(v, "ar_load");
    v = '{srst: 1'b0, load: 1'b0, tick: 1'b1, ld_day: 5'd0, ld_mon: 4'd0,
          year: 12'd1970, e_day: 5'd1, e_mon: 4'd1, e_leap: 1'b0, e_yt: 1'b1, e_err: 1'b0};
    apply(v, "ar_tick");
    #1 rst_n = 1'b0;
    #1;
    check("ar ytick", 32'(year_tick), 32'd0);
    check("ar day",   32'(day),       32'd1);
    check("ar month", 32'(month),     32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{srst: 1'b0, load: 1'b0, tick: 1'b0, ld_day: 5'd0, ld_mon: 4'd0,
          year: 12'd1970, e_day: 5'd1, e_mon: 4'd1, e_leap: 1'b0, e_yt: 1'b0, e_err: 1'b0};
    apply(v, "ar_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
